// File: rtl/exe_issue_ctrl.sv
// exe_issue_ctrl: sequences one instruction at a time through the
// combinational execute datapath or the external multi-cycle MDU.
// Ports:
//   id_*       instruction in (valid/ready)
//   ex_*       latched fields out to the datapath; datapath results back in
//   mdu_*      MDU start pulse, done strobe and result
//   wb_*       held result (valid/ready)
//   redirect_* PC redirect, qualified by the wb handshake
module exe_issue_ctrl #(
  parameter int XLEN        = 64,
  parameter int MDU_TIMEOUT = 64,
  parameter int TO_W        = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [4:0]      id_inst_type,
  input  logic [7:0]      id_inst_opcode,
  input  logic            id_is_mdu,
  input  logic [XLEN-1:0] id_op1,
  input  logic [XLEN-1:0] id_op2,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_offset,
  input  logic            id_w,
  output logic [4:0]      ex_inst_type,
  output logic [7:0]      ex_inst_opcode,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_offset,
  output logic            ex_w,
  output logic            ex_pc_ena,
  input  logic [XLEN-1:0] ex_rd_data,
  input  logic            ex_rd_ena,
  input  logic            ex_pc_ena_if,
  input  logic [XLEN-1:0] ex_pc_if,
  output logic            mdu_req,
  input  logic            mdu_done,
  input  logic [XLEN-1:0] mdu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_rd_data,
  output logic            wb_rd_ena,
  output logic            wb_err,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EXEC   = 3'd1;
  localparam logic [2:0] S_MWAIT  = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  logic [4:0]      type_q, type_d;
  logic [7:0]      opc_q, opc_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] off_q, off_d;
  logic            w_q, w_d;
  logic            mdu_q, mdu_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rena_q, rena_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic            err_q, err_d;
  logic            accept;

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    opc_d   = opc_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    pc_d    = pc_q;
    off_d   = off_q;
    w_d     = w_q;
    mdu_d   = mdu_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rena_d  = rena_q;
    redir_d = redir_q;
    rpc_d   = rpc_q;
    err_d   = err_q;

    id_ready = ~flush &
      ((state_q == S_IDLE) |
       ((state_q == S_RESULT) & wb_ready));
    accept = id_valid & id_ready;

    case (state_q)
      S_IDLE: ;
      S_EXEC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mdu_q) begin
          cnt_d   = '0;
          state_d = S_MWAIT;
        end else begin
          rdata_d = ex_rd_data;
          rena_d  = ex_rd_ena;
          redir_d = ex_pc_ena_if;
          rpc_d   = ex_pc_if;
          err_d   = 1'b0;
          state_d = S_RESULT;
        end
      end
      S_MWAIT: begin
        if (flush) begin
          // keep counting so the drain still times out
          cnt_d   = cnt_q + TO_W'(1);
          state_d = mdu_done ? S_IDLE : S_DRAIN;
        end else if (mdu_done) begin
          rdata_d = mdu_result;
          rena_d  = 1'b1;
          redir_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_RESULT;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = '1;
          rena_d  = 1'b0;
          redir_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESULT;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      S_RESULT: begin
        if (flush || wb_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mdu_done || cnt_q >= TO_LAST) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      type_d  = id_inst_type;
      opc_d   = id_inst_opcode;
      op1_d   = id_op1;
      op2_d   = id_op2;
      pc_d    = id_pc;
      off_d   = id_offset;
      w_d     = id_w;
      mdu_d   = id_is_mdu;
      state_d = S_EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q  <= '0;
      opc_q   <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      pc_q    <= '0;
      off_q   <= '0;
      w_q     <= 1'b0;
      mdu_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rena_q  <= 1'b0;
      redir_q <= 1'b0;
      rpc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      opc_q   <= opc_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      pc_q    <= pc_d;
      off_q   <= off_d;
      w_q     <= w_d;
      mdu_q   <= mdu_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rena_q  <= rena_d;
      redir_q <= redir_d;
      rpc_q   <= rpc_d;
      err_q   <= err_d;
    end
  end

  assign ex_inst_type   = type_q;
  assign ex_inst_opcode = opc_q;
  assign ex_op1         = op1_q;
  assign ex_op2         = op2_q;
  assign ex_pc          = pc_q;
  assign ex_offset      = off_q;
  assign ex_w           = w_q;
  assign ex_pc_ena      = (state_q == S_EXEC);

  // a flushed EXEC never starts the MDU
  assign mdu_req = (state_q == S_EXEC) & mdu_q & ~flush;

  assign wb_valid   = (state_q == S_RESULT) & ~flush;
  assign wb_rd_data = rdata_q;
  assign wb_rd_ena  = rena_q;
  assign wb_err     = err_q;

  assign redirect_valid = (state_q == S_RESULT) & wb_ready &
                          redir_q & ~flush;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// tb_exe_issue_ctrl: directed bench for exe_issue_ctrl.
// Vector table for ALU ops plus hand sequences for MDU/flush/timeout.
module tb_exe_issue_ctrl;

  localparam int XLEN = 64;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_BEQ = 8'h10;
  localparam logic [7:0] OP_JAL = 8'h20;
  localparam logic [7:0] OP_MUL = 8'h30;

  logic            clk, rst, flush;
  logic            id_valid, id_ready;
  logic [4:0]      id_inst_type;
  logic [7:0]      id_inst_opcode;
  logic            id_is_mdu;
  logic [XLEN-1:0] id_op1, id_op2, id_pc, id_offset;
  logic            id_w;
  logic [4:0]      ex_inst_type;
  logic [7:0]      ex_inst_opcode;
  logic [XLEN-1:0] ex_op1, ex_op2, ex_pc, ex_offset;
  logic            ex_w, ex_pc_ena;
  logic [XLEN-1:0] ex_rd_data;
  logic            ex_rd_ena, ex_pc_ena_if;
  logic [XLEN-1:0] ex_pc_if;
  logic            mdu_req, mdu_done;
  logic [XLEN-1:0] mdu_result;
  logic            wb_valid, wb_ready;
  logic [XLEN-1:0] wb_rd_data;
  logic            wb_rd_ena, wb_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  int n_chk;
  int n_fail;
  int req_cnt;

  exe_issue_ctrl #(
    .XLEN(XLEN), .MDU_TIMEOUT(8), .TO_W(7)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_inst_type(id_inst_type), .id_inst_opcode(id_inst_opcode),
    .id_is_mdu(id_is_mdu), .id_op1(id_op1), .id_op2(id_op2),
    .id_pc(id_pc), .id_offset(id_offset), .id_w(id_w),
    .ex_inst_type(ex_inst_type), .ex_inst_opcode(ex_inst_opcode),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_pc(ex_pc),
    .ex_offset(ex_offset), .ex_w(ex_w), .ex_pc_ena(ex_pc_ena),
    .ex_rd_data(ex_rd_data), .ex_rd_ena(ex_rd_ena),
    .ex_pc_ena_if(ex_pc_ena_if), .ex_pc_if(ex_pc_if),
    .mdu_req(mdu_req), .mdu_done(mdu_done), .mdu_result(mdu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd_data(wb_rd_data), .wb_rd_ena(wb_rd_ena), .wb_err(wb_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in for the combinational execute datapath
  always_comb begin
    ex_rd_data   = '0;
    ex_rd_ena    = 1'b0;
    ex_pc_ena_if = 1'b0;
    ex_pc_if     = '0;
    case (ex_inst_opcode)
      OP_ADD: begin
        ex_rd_data = ex_op1 + ex_op2;
        ex_rd_ena  = 1'b1;
      end
      OP_SUB: begin
        ex_rd_data = ex_op1 - ex_op2;
        ex_rd_ena  = 1'b1;
      end
      OP_BEQ: begin
        ex_pc_ena_if = (ex_op1 == ex_op2);
        ex_pc_if     = ex_pc + ex_offset;
      end
      OP_JAL: begin
        ex_rd_data   = ex_pc + 64'd4;
        ex_rd_ena    = 1'b1;
        ex_pc_ena_if = 1'b1;
        ex_pc_if     = ex_pc + ex_offset;
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (mdu_req) req_cnt = req_cnt + 1;
  end

  typedef struct {
    logic [7:0]      opc;
    logic [XLEN-1:0] op1, op2, pc, off;
    logic [XLEN-1:0] exp_data;
    logic            exp_ena;
    logic            exp_redir;
    logic [XLEN-1:0] exp_rpc;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name,
                     input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] opc, input logic mdu,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] pc,
                       input logic [XLEN-1:0] off);
    id_valid       = 1'b1;
    id_inst_type   = 5'd3;
    id_inst_opcode = opc;
    id_is_mdu      = mdu;
    id_op1         = a;
    id_op2         = b;
    id_pc          = pc;
    id_offset      = off;
    id_w           = 1'b0;
  endtask

  initial begin
    int n;
    n_chk = 0; n_fail = 0; req_cnt = 0;
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0;
    id_inst_type = '0; id_inst_opcode = '0; id_is_mdu = 1'b0;
    id_op1 = '0; id_op2 = '0; id_pc = '0; id_offset = '0; id_w = 1'b0;
    mdu_done = 1'b0; mdu_result = '0; wb_ready = 1'b0;

    vecs[0] = '{OP_ADD, 64'd5, 64'd7, 64'h0, 64'h0,
                64'd12, 1'b1, 1'b0, 64'h0};
    vecs[1] = '{OP_SUB, 64'd10, 64'd3, 64'h0, 64'h0,
                64'd7, 1'b1, 1'b0, 64'h0};
    vecs[2] = '{OP_BEQ, 64'd3, 64'd3, 64'h8000_0000, 64'h10,
                64'd0, 1'b0, 1'b1, 64'h8000_0010};
    vecs[3] = '{OP_BEQ, 64'd3, 64'd4, 64'h8000_0000, 64'h10,
                64'd0, 1'b0, 1'b0, 64'h0};
    vecs[4] = '{OP_JAL, 64'd0, 64'd0, 64'h1000, 64'h40,
                64'h1004, 1'b1, 1'b1, 64'h1040};

    // reset state
    step(); step();
    chk("rst_id_ready", 64'(id_ready), 64'd1);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_mdu_req", 64'(mdu_req), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_wb_data", wb_rd_data, 64'd0);
    chk("rst_ex_op1", ex_op1, 64'd0);
    chk("rst_pc_ena", 64'(ex_pc_ena), 64'd0);
    rst = 1'b0;
    step();

    // table-driven ALU/branch vectors
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].opc, 1'b0, vecs[i].op1, vecs[i].op2,
            vecs[i].pc, vecs[i].off);
      #1;
      chk($sformatf("v%0d_id_ready", i), 64'(id_ready), 64'd1);
      step();
      id_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_pc_ena", i), 64'(ex_pc_ena), 64'd1);
      chk($sformatf("v%0d_wbv_early", i), 64'(wb_valid), 64'd0);
      step();
      chk($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'd1);
      chk($sformatf("v%0d_data", i), wb_rd_data, vecs[i].exp_data);
      chk($sformatf("v%0d_rd_ena", i), 64'(wb_rd_ena),
          64'(vecs[i].exp_ena));
      chk($sformatf("v%0d_err", i), 64'(wb_err), 64'd0);
      chk($sformatf("v%0d_redir_pre", i), 64'(redirect_valid), 64'd0);
      wb_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_redir", i), 64'(redirect_valid),
          64'(vecs[i].exp_redir));
      if (vecs[i].exp_redir)
        chk($sformatf("v%0d_rpc", i), redirect_pc, vecs[i].exp_rpc);
      step();
      wb_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_retired", i), 64'(wb_valid), 64'd0);
    end

    // back-to-back ALU ops
    wb_ready = 1'b1;
    issue(OP_ADD, 1'b0, 64'd1, 64'd2, 64'h0, 64'h0);
    step();
    issue(OP_ADD, 1'b0, 64'd4, 64'd4, 64'h0, 64'h0);
    #1;
    chk("b2b_exec_ready", 64'(id_ready), 64'd0);
    step();
    chk("b2b_wbv1", 64'(wb_valid), 64'd1);
    chk("b2b_data1", wb_rd_data, 64'd3);
    chk("b2b_ready1", 64'(id_ready), 64'd1);
    step();
    id_valid = 1'b0;
    #1;
    chk("b2b_gap", 64'(wb_valid), 64'd0);
    chk("b2b_op1", ex_op1, 64'd4);
    step();
    chk("b2b_wbv2", 64'(wb_valid), 64'd1);
    chk("b2b_data2", wb_rd_data, 64'd8);
    step();
    wb_ready = 1'b0;
    #1;
    chk("b2b_idle", 64'(wb_valid), 64'd0);

    // MDU op with delayed done and WB back-pressure
    req_cnt = 0;
    issue(OP_MUL, 1'b1, 64'd6, 64'd7, 64'h0, 64'h0);
    step();
    id_valid = 1'b0;
    #1;
    chk("mdu_req_on", 64'(mdu_req), 64'd1);
    step();
    chk("mdu_req_off", 64'(mdu_req), 64'd0);
    chk("mdu_wait_ready", 64'(id_ready), 64'd0);
    step(); step(); step();
    mdu_done = 1'b1;
    mdu_result = 64'h2A;
    step();
    mdu_done = 1'b0;
    mdu_result = 64'hDEAD;
    for (int k = 0; k < 3; k++) begin
      chk("mdu_hold_valid", 64'(wb_valid), 64'd1);
      chk("mdu_hold_data", wb_rd_data, 64'h2A);
      chk("mdu_hold_ready", 64'(id_ready), 64'd0);
      step();
    end
    wb_ready = 1'b1;
    #1;
    chk("mdu_ready_on", 64'(id_ready), 64'd1);
    chk("mdu_rd_ena", 64'(wb_rd_ena), 64'd1);
    chk("mdu_no_redir", 64'(redirect_valid), 64'd0);
    step();
    wb_ready = 1'b0;
    #1;
    chk("mdu_idle", 64'(wb_valid), 64'd0);
    chk("mdu_req_count", 64'(req_cnt), 64'd1);

    // flush during MDU wait, done arrives later
    issue(OP_MUL, 1'b1, 64'd2, 64'd2, 64'h0, 64'h0);
    step();
    id_valid = 1'b0;
    step();
    flush = 1'b1;
    #1;
    chk("fl_id_ready", 64'(id_ready), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("drain_ready", 64'(id_ready), 64'd0);
    chk("drain_wbv", 64'(wb_valid), 64'd0);
    step();
    chk("drain_req", 64'(mdu_req), 64'd0);
    step();
    mdu_done = 1'b1;
    mdu_result = 64'h55;
    #1;
    chk("drain_done_wbv", 64'(wb_valid), 64'd0);
    step();
    mdu_done = 1'b0;
    #1;
    chk("drain_exit", 64'(id_ready), 64'd1);
    chk("drain_no_wb", 64'(wb_valid), 64'd0);

    // flush + wb_ready on a taken branch in RESULT
    issue(OP_BEQ, 1'b0, 64'd3, 64'd3, 64'h8000_0000, 64'h10);
    step();
    id_valid = 1'b0;
    step();
    flush = 1'b1;
    wb_ready = 1'b1;
    #1;
    chk("flres_redir", 64'(redirect_valid), 64'd0);
    chk("flres_wbv", 64'(wb_valid), 64'd0);
    step();
    flush = 1'b0;
    wb_ready = 1'b0;
    #1;
    chk("flres_idle", 64'(wb_valid), 64'd0);
    chk("flres_ready", 64'(id_ready), 64'd1);

    // flush + done together in MDU wait
    issue(OP_MUL, 1'b1, 64'd1, 64'd1, 64'h0, 64'h0);
    step();
    id_valid = 1'b0;
    step();
    flush = 1'b1;
    mdu_done = 1'b1;
    step();
    flush = 1'b0;
    mdu_done = 1'b0;
    #1;
    chk("fldone_idle", 64'(id_ready), 64'd1);
    chk("fldone_wbv", 64'(wb_valid), 64'd0);

    // late done in IDLE is ignored
    mdu_done = 1'b1;
    step();
    mdu_done = 1'b0;
    #1;
    chk("late_done", 64'(wb_valid), 64'd0);

    // MDU timeout
    issue(OP_MUL, 1'b1, 64'd9, 64'd9, 64'h0, 64'h0);
    step();
    id_valid = 1'b0;
    n = 0;
    while (!wb_valid && n < 30) begin
      step();
      n++;
    end
    chk("to_latency", 64'(n), 64'd9);
    chk("to_data", wb_rd_data, {XLEN{1'b1}});
    chk("to_rd_ena", 64'(wb_rd_ena), 64'd0);
    chk("to_err", 64'(wb_err), 64'd1);

    // async reset while holding the timeout result
    #1;
    rst = 1'b1;
    #1;
    chk("arst_wbv", 64'(wb_valid), 64'd0);
    chk("arst_err", 64'(wb_err), 64'd0);
    chk("arst_data", wb_rd_data, 64'd0);
    chk("arst_ready", 64'(id_ready), 64'd1);
    step();
    rst = 1'b0;
    step();

    // async reset drops an in-flight mdu_req
    issue(OP_MUL, 1'b1, 64'd3, 64'd5, 64'h0, 64'h0);
    step();
    id_valid = 1'b0;
    #1;
    chk("arst2_req_on", 64'(mdu_req), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst2_req", 64'(mdu_req), 64'd0);
    chk("arst2_pc_ena", 64'(ex_pc_ena), 64'd0);
    chk("arst2_op1", ex_op1, 64'd0);
    step();
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
